// File: rtl/inst_queue.sv
// Dual-issue instruction queue between fetch and the two decoders. It also serves
// as the IF->ID register: a circular buffer of {pc, inst} entries that flush empties.
module inst_queue #(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [31:0]      in_pc,
  input  logic [63:0]      inst_in,
  output logic             in_ready,
  input  logic [1:0]       pop_cnt,
  output logic             out_valid1,
  output logic [31:0]      out_pc1,
  output logic [31:0]      out_inst1,
  output logic             out_valid2,
  output logic [31:0]      out_pc2,
  output logic [31:0]      out_inst2,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0]   DEPTH_C   = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ZERO  = '0;
  localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_TWO   = (PTR_W+1)'(2);
  localparam logic [PTR_W-1:0] PTR_ONE   = (PTR_W)'(1);

  // Each entry is {pc, inst}; contents are never cleared, only the pointers are.
  logic [63:0]      mem [DEPTH];

  logic [PTR_W-1:0] head_reg, head_next;
  logic [PTR_W-1:0] tail_reg, tail_next;
  logic [PTR_W:0]   count_reg, count_next;

  logic             push_en;
  logic             push_two;
  logic [PTR_W:0]   push_num;
  logic [PTR_W:0]   pop_req;
  logic [PTR_W:0]   pop_num;
  logic [PTR_W-1:0] tail_plus1;
  logic [PTR_W-1:0] head_plus1;
  logic [63:0]      wr_lo;
  logic [63:0]      wr_hi;
  logic [63:0]      rd1;
  logic [63:0]      rd2;

  // Readiness looks only at the current occupancy, so same-cycle pops never make room.
  assign in_ready   = (count_reg <= (DEPTH_C - CNT_TWO));
  assign push_en    = in_valid && in_ready && !flush;
  // A packet whose pc points at the upper word carries a single useful instruction.
  assign push_two   = !in_pc[2];
  assign push_num   = !push_en ? CNT_ZERO : (push_two ? CNT_TWO : CNT_ONE);

  always_comb begin
    pop_req = CNT_ZERO;
    case (pop_cnt)
      2'd0:    pop_req = CNT_ZERO;
      2'd1:    pop_req = CNT_ONE;
      default: pop_req = CNT_TWO;
    endcase
  end

  assign pop_num    = (pop_req > count_reg) ? count_reg : pop_req;

  assign tail_plus1 = tail_reg + PTR_ONE;
  assign head_plus1 = head_reg + PTR_ONE;

  assign head_next  = head_reg + pop_num[PTR_W-1:0];
  assign tail_next  = tail_reg + push_num[PTR_W-1:0];
  assign count_next = count_reg + push_num - pop_num;

  assign wr_lo = {in_pc, (push_two ? inst_in[31:0] : inst_in[63:32])};
  assign wr_hi = {in_pc + 32'd4, inst_in[63:32]};

  always_ff @(posedge clk) begin
    if (push_en) begin
      mem[tail_reg] <= wr_lo;
      if (push_two) begin
        mem[tail_plus1] <= wr_hi;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else if (flush) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  assign rd1 = mem[head_reg];
  assign rd2 = mem[head_plus1];

  // Invalid slots present zeros so decoders never see stale storage.
  assign out_valid1 = (count_reg >= CNT_ONE);
  assign out_valid2 = (count_reg >= CNT_TWO);
  assign out_pc1    = out_valid1 ? rd1[63:32] : 32'd0;
  assign out_inst1  = out_valid1 ? rd1[31:0]  : 32'd0;
  assign out_pc2    = out_valid2 ? rd2[63:32] : 32'd0;
  assign out_inst2  = out_valid2 ? rd2[31:0]  : 32'd0;
  assign count      = count_reg;

endmodule

// File: tb/tb_inst_queue.sv
// Bench for inst_queue: directed scenarios plus random traffic, compared against
// a queue-based model of the instruction stream.
module tb_inst_queue;

  localparam int DEPTH = 8;
  localparam int PTR_W = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic [31:0]      in_pc;
  logic [63:0]      inst_in;
  logic             in_ready;
  logic [1:0]       pop_cnt;
  logic             out_valid1;
  logic [31:0]      out_pc1;
  logic [31:0]      out_inst1;
  logic             out_valid2;
  logic [31:0]      out_pc2;
  logic [31:0]      out_inst2;
  logic [PTR_W:0]   count;

  int checks = 0;
  int errors = 0;

  // Model: in-order list of {pc, inst} still held by the queue.
  logic [63:0] mq[$];

  inst_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_pc(in_pc),
    .inst_in(inst_in), .in_ready(in_ready), .pop_cnt(pop_cnt),
    .out_valid1(out_valid1), .out_pc1(out_pc1), .out_inst1(out_inst1),
    .out_valid2(out_valid2), .out_pc2(out_pc2), .out_inst2(out_inst2),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [63:0] e1;
    logic [63:0] e2;
    e1 = (mq.size() >= 1) ? mq[0] : 64'd0;
    e2 = (mq.size() >= 2) ? mq[1] : 64'd0;
    chk({tag, ".count"}, 32'(count), 32'(mq.size()));
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(mq.size() <= DEPTH - 2));
    chk({tag, ".valid1"}, 32'(out_valid1), 32'(mq.size() >= 1));
    chk({tag, ".valid2"}, 32'(out_valid2), 32'(mq.size() >= 2));
    chk({tag, ".pc1"}, out_pc1, e1[63:32]);
    chk({tag, ".inst1"}, out_inst1, e1[31:0]);
    chk({tag, ".pc2"}, out_pc2, e2[63:32]);
    chk({tag, ".inst2"}, out_inst2, e2[31:0]);
    $display("step %-10s v=%0d pc=%h pop=%0d fl=%0d -> count=%0d slot1=%h/%h slot2=%h/%h",
             tag, in_valid, in_pc, pop_cnt, flush, count, out_pc1, out_inst1, out_pc2, out_inst2);
  endtask

  // Reference behaviour from the queue's rules, applied to the pre-edge model state.
  task automatic model_update(input logic v, input logic [31:0] pc, input logic [63:0] d,
                              input logic [1:0] p, input logic f);
    int  n;
    bit  rdy;
    rdy = (mq.size() <= DEPTH - 2);
    if (f) begin
      mq.delete();
      return;
    end
    n = (p == 2'd3) ? 2 : int'(p);
    if (n > mq.size()) n = mq.size();
    for (int i = 0; i < n; i++) void'(mq.pop_front());
    if (v && rdy) begin
      if (pc[2] == 1'b0) begin
        mq.push_back({pc, d[31:0]});
        mq.push_back({pc + 32'd4, d[63:32]});
      end else begin
        mq.push_back({pc, d[63:32]});
      end
    end
  endtask

  task automatic step(input string tag, input logic v, input logic [31:0] pc,
                      input logic [63:0] d, input logic [1:0] p, input logic f);
    in_valid = v; in_pc = pc; inst_in = d; pop_cnt = p; flush = f;
    model_update(v, pc, d, p, f);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [31:0] rpc;
    logic [63:0] rdat;
    logic        rv;
    logic        rf;
    logic [1:0]  rp;

    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_pc = '0; inst_in = '0; pop_cnt = '0;
    #12;
    check_all("reset");
    rst = 1'b1;

    step("empty_pop", 1'b0, 32'h0, 64'h0, 2'd2, 1'b0);

    step("push1000", 1'b1, 32'h1000, 64'h00200093_00100093, 2'd0, 1'b0);
    chk("basic.pc1", out_pc1, 32'h1000);
    chk("basic.inst1", out_inst1, 32'h00100093);
    chk("basic.pc2", out_pc2, 32'h1004);
    chk("basic.inst2", out_inst2, 32'h00200093);
    step("pop1", 1'b0, 32'h0, 64'h0, 2'd1, 1'b0);
    chk("pop1.inst1", out_inst1, 32'h00200093);
    step("pop1b", 1'b0, 32'h0, 64'h0, 2'd1, 1'b0);

    step("odd2004", 1'b1, 32'h2004, 64'hAAAAAAAA_BBBBBBBB, 2'd0, 1'b0);
    chk("odd.inst1", out_inst1, 32'hAAAAAAAA);
    chk("odd.count", 32'(count), 32'd1);
    step("drain", 1'b0, 32'h0, 64'h0, 2'd3, 1'b0);

    for (int i = 0; i < 4; i++)
      step("fill", 1'b1, 32'h3000 + 32'(8 * i), {32'hC000_0000 + 32'(2*i+1), 32'hC000_0000 + 32'(2*i)}, 2'd0, 1'b0);
    chk("full.ready", 32'(in_ready), 32'd0);
    step("fifth", 1'b1, 32'h4000, 64'hDEAD_BEEF_0BAD_F00D, 2'd0, 1'b0);
    chk("fifth.count", 32'(count), 32'd8);
    step("fullpop", 1'b1, 32'h4000, 64'hDEAD_BEEF_0BAD_F00D, 2'd2, 1'b0);
    chk("fullpop.count", 32'(count), 32'd6);
    step("accept", 1'b1, 32'h4000, 64'hDEAD_BEEF_0BAD_F00D, 2'd0, 1'b0);

    // Walk pointers to 6, then refill so the next push/pop pair wraps.
    step("flush0", 1'b0, 32'h0, 64'h0, 2'd0, 1'b1);
    for (int i = 0; i < 3; i++)
      step("adv_push", 1'b1, 32'h5000 + 32'(8 * i), {32'h5100_0000 + 32'(i), 32'h5000_0000 + 32'(i)}, 2'd0, 1'b0);
    for (int i = 0; i < 3; i++)
      step("adv_pop", 1'b0, 32'h0, 64'h0, 2'd2, 1'b0);
    step("wrap_a", 1'b1, 32'h6000, 64'h6111_1111_6000_0000, 2'd0, 1'b0);
    step("wrap_b", 1'b1, 32'h6008, 64'h6333_3333_6222_2222, 2'd0, 1'b0);
    step("wrap_pp", 1'b1, 32'h6010, 64'h6555_5555_6444_4444, 2'd2, 1'b0);
    chk("wrap.pc1", out_pc1, 32'h6008);
    chk("wrap.count", 32'(count), 32'd4);

    step("flush1", 1'b0, 32'h0, 64'h0, 2'd0, 1'b1);
    step("f5a", 1'b1, 32'h7000, 64'h7001_0000_7000_0000, 2'd0, 1'b0);
    step("f5b", 1'b1, 32'h7008, 64'h7003_0000_7002_0000, 2'd0, 1'b0);
    step("f5c", 1'b1, 32'h7014, 64'h7005_0000_7004_0000, 2'd0, 1'b0);
    chk("f5.count", 32'(count), 32'd5);
    step("flushpri", 1'b1, 32'h7100, 64'h7101_0000_7100_0000, 2'd2, 1'b1);
    chk("flushpri.count", 32'(count), 32'd0);
    step("postflush", 1'b1, 32'h7200, 64'h7201_0000_7200_0000, 2'd0, 1'b0);

    // Asynchronous reset between edges clears the outputs without a clock.
    in_valid = 1'b0; pop_cnt = 2'd0;
    #3;
    rst = 1'b0;
    mq.delete();
    #1;
    check_all("async_rst");
    rst = 1'b1;

    for (int i = 0; i < 400; i++) begin
      rpc = $urandom();
      rpc[1:0] = 2'b00;
      rdat = {$urandom(), $urandom()};
      rv = ($urandom_range(0, 3) != 0);
      rp = 2'($urandom_range(0, 3));
      rf = ($urandom_range(0, 24) == 0);
      step("rand", rv, rpc, rdat, rp, rf);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
